spi_mode0_slave: RTL and testbench

SPI mode 0 (CPOL=0, CPHA=0) slave. It is the responder end for the existing SPI mode 0 master.
- Oversamples SCLK/SS/MOSI in the system clock domain.
- Shifts MOSI in MSB-first on SCLK rising edges and drives MISO MSB-first, changing on SCLK falling edges.
- Presents each received byte to on-chip logic and takes the next transmit byte from it.
- Supports multi-byte transfers while SS stays low.

---
 rtl/spi_mode0_slave.sv | 152 +++++++++++++++
 tb/tb_spi_mode0_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_mode0_slave.sv
// SPI mode 0 (CPOL=0, CPHA=0) slave with oversampled SCLK/SS/MOSI and a byte-wide parallel interface.
// Optional MISO tristate with an output-enable port: define SPI_SLAVE_MISO_TRISTATE_EN.
module spi_mode0_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCLK,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic                  TX_REQ,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VALID,
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    output logic                  MISO_OE,
`endif
    output logic                  BUSY
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sclk_sync, ss_sync, mosi_sync;
    logic                    sclk_s, ss_s, mosi_s, sclk_d, ss_d;
    logic                    sclk_rise, sclk_fall, ss_fall;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   r_sr, w_sr, dout_r;
    logic                    miso_r, dout_valid_r, tx_req, busy, miso_oe;

    // MOSI goes through the same depth as SCLK so the sampled bit lines up with the detected rise.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;
    assign ss_fall   = ss_d & ~ss_s;

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (ss_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A fall that coincides with deselect closes the transfer, so no further byte is requested.
    always_comb begin
        tx_req  = 1'b0;
        busy    = 1'b0;
        miso_oe = 1'b0;
        case (state)
            LOAD: begin
                tx_req  = 1'b1;
                busy    = 1'b1;
                miso_oe = 1'b1;
            end
            SHIFT: begin
                tx_req  = sclk_fall && (bit_cnt == '0) && !ss_s;
                busy    = 1'b1;
                miso_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bit_cnt      <= '0;
            r_sr         <= '0;
            w_sr         <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            miso_r       <= 1'b0;
        end else begin
            dout_valid_r <= 1'b0;
            case (state)
                LOAD: begin
                    w_sr    <= DIN;
                    miso_r  <= DIN[DATA_WIDTH-1];
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        r_sr <= {r_sr[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            dout_r       <= {r_sr[DATA_WIDTH-2:0], mosi_s};
                            dout_valid_r <= 1'b1;
                            bit_cnt      <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0) begin
                            w_sr   <= w_sr << 1;
                            miso_r <= w_sr[DATA_WIDTH-2];
                        end else if (!ss_s) begin
                            w_sr   <= DIN;
                            miso_r <= DIN[DATA_WIDTH-1];
                        end
                    end
                    // Deselect drops any partial byte and parks MISO low on the way to IDLE.
                    if (ss_s) begin
                        bit_cnt <= '0;
                        miso_r  <= 1'b0;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_REQ     = tx_req;
    assign DOUT       = dout_r;
    assign DOUT_VALID = dout_valid_r;
    assign BUSY       = busy;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO_OE    = miso_oe;
    assign MISO       = miso_oe ? miso_r : 1'bz;
`else
    assign MISO       = miso_r;
`endif
endmodule

// File: tb/tb_spi_mode0_slave.sv
// Directed bench for spi_mode0_slave: a behavioural mode 0 master drives SCLK/SS/MOSI and reads MISO.
module tb_spi_mode0_slave;
    localparam int HALF = 8;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SCLK = 1'b0;
    logic       SS = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       MISO, TX_REQ, DOUT_VALID, BUSY;
    logic [7:0] DOUT;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    logic       MISO_OE;
`endif

    int vectors = 0;
    int miscompares = 0;
    int tx_cnt = 0;
    int dv_cnt = 0;
    int idle_miso_bad = 0;
    logic [7:0] dv_hist [0:15];

    spi_mode0_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .DIN(DIN), .TX_REQ(TX_REQ), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        .MISO_OE(MISO_OE),
`endif
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Pulse counters and idle-MISO watch, sampled away from the active edge.
    always @(negedge CLK) begin
        if (RST) begin
            if (TX_REQ) tx_cnt++;
            if (DOUT_VALID) begin
                dv_hist[dv_cnt[3:0]] = DOUT;
                dv_cnt++;
            end
            if (!BUSY && MISO !== IDLE_MISO) idle_miso_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One mode 0 bit: MOSI set while SCLK low, MISO read at the rising edge.
    task automatic spi_bit(input logic b, output logic r, input logic release_ss);
        MOSI = b;
        wait_clk(HALF);
        SCLK = 1'b1;
        r = MISO;
        wait_clk(HALF);
        SCLK = 1'b0;
        if (release_ss) SS = 1'b1;
    endtask

    // The master releases SS together with the closing SCLK fall of the last byte.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, input logic last);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r, last && (i == 0));
            rx[i] = r;
        end
    endtask

    task automatic select();
        @(negedge CLK);
        SS = 1'b0;
        wait_clk(HALF);
    endtask

    initial begin
        logic [7:0] rx0, rx1;
        logic       r;
        int         tx0, dv0, dvi;

        wait_clk(3);
        RST = 1'b1;
        wait_clk(2);
        chk("reset_miso", {31'd0, MISO}, {31'd0, IDLE_MISO});
        chk("reset_dout", {24'd0, DOUT}, 32'h00);
        chk("reset_dv", {31'd0, DOUT_VALID}, 32'd0);
        chk("reset_txreq", {31'd0, TX_REQ}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        chk("reset_oe", {31'd0, MISO_OE}, 32'd0);
`endif

        // Single byte: slave sends 0x3C, master sends 0xA5.
        tx0 = tx_cnt; dv0 = dv_cnt;
        DIN = 8'h3C;
        select();
        chk("single_busy", {31'd0, BUSY}, 32'd1);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        chk("single_oe", {31'd0, MISO_OE}, 32'd1);
`endif
        spi_byte(8'hA5, rx0, 1'b1);
        wait_clk(10);
        chk("single_rx", {24'd0, rx0}, 32'h3C);
        chk("single_dout", {24'd0, DOUT}, 32'hA5);
        chk("single_dv", dv_cnt - dv0, 1);
        chk("single_txreq", tx_cnt - tx0, 1);
        chk("single_busy_end", {31'd0, BUSY}, 32'd0);
        chk("single_miso_end", {31'd0, MISO}, {31'd0, IDLE_MISO});
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        chk("single_oe_end", {31'd0, MISO_OE}, 32'd0);
`endif

        // Back-to-back: 0x12, 0x34 in; 0xF0, 0x0F out.
        tx0 = tx_cnt; dv0 = dv_cnt;
        DIN = 8'hF0;
        select();
        DIN = 8'h0F;
        spi_byte(8'h12, rx0, 1'b0);
        spi_byte(8'h34, rx1, 1'b1);
        wait_clk(10);
        chk("b2b_rx0", {24'd0, rx0}, 32'hF0);
        chk("b2b_rx1", {24'd0, rx1}, 32'h0F);
        chk("b2b_dv", dv_cnt - dv0, 2);
        chk("b2b_txreq", tx_cnt - tx0, 2);
        dvi = dv0 % 16;
        chk("b2b_dout0", {24'd0, dv_hist[dvi]}, 32'h12);
        dvi = (dv0 + 1) % 16;
        chk("b2b_dout1", {24'd0, dv_hist[dvi]}, 32'h34);

        // Abort after 5 rises of 0xFF, then a full 0x81.
        dv0 = dv_cnt;
        DIN = 8'h55;
        select();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r, 1'b0);
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(10);
        chk("abort_dv", dv_cnt - dv0, 0);
        chk("abort_dout", {24'd0, DOUT}, 32'h34);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_miso", {31'd0, MISO}, {31'd0, IDLE_MISO});
        select();
        spi_byte(8'h81, rx0, 1'b1);
        wait_clk(10);
        chk("abort_next_dout", {24'd0, DOUT}, 32'h81);
        chk("abort_next_dv", dv_cnt - dv0, 1);
        chk("abort_next_rx", {24'd0, rx0}, 32'h55);

        // Reset after 3 bits, then a full 0x5A.
        DIN = 8'hE7;
        select();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        SS = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        chk("rst_dout", {24'd0, DOUT}, 32'h00);
        chk("rst_miso", {31'd0, MISO}, {31'd0, IDLE_MISO});
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_txreq", {31'd0, TX_REQ}, 32'd0);
        chk("rst_dv", {31'd0, DOUT_VALID}, 32'd0);
        wait_clk(4);
        dv0 = dv_cnt;
        DIN = 8'hC3;
        select();
        spi_byte(8'h5A, rx0, 1'b1);
        wait_clk(10);
        chk("rst_next_dout", {24'd0, DOUT}, 32'h5A);
        chk("rst_next_dv", dv_cnt - dv0, 1);
        chk("rst_next_rx", {24'd0, rx0}, 32'hC3);

        // Noise while deselected.
        tx0 = tx_cnt; dv0 = dv_cnt;
        for (int i = 0; i < 16; i++) begin
            MOSI = i[0];
            wait_clk(HALF);
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
        wait_clk(6);
        chk("noise_dv", dv_cnt - dv0, 0);
        chk("noise_txreq", tx_cnt - tx0, 0);
        chk("noise_busy", {31'd0, BUSY}, 32'd0);
        chk("noise_miso", {31'd0, MISO}, {31'd0, IDLE_MISO});
        chk("noise_dout", {24'd0, DOUT}, 32'h5A);
        chk("idle_miso_watch", idle_miso_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
